// File: rtl/dot_scan_controller.sv
// Read-side sequencer for the dot pattern store: walks a latched rectangular window,
// samples the store per dot and emits one drive pulse of programmable length per set dot.
module dot_scan_controller #(
   parameter int unsigned MEM_LENGTH         = 48,
   parameter int unsigned MEM_ADDRESS_LENGTH = 6,
   parameter int unsigned DWELL_WIDTH        = 16
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          stop,
   input  logic                          loop_enable,
   input  logic                          col_major_sel,
   input  logic [MEM_ADDRESS_LENGTH-1:0] last_row,
   input  logic [MEM_ADDRESS_LENGTH-1:0] last_col,
   input  logic [DWELL_WIDTH-1:0]        dwell_cycles,
   input  logic                          firing_bit,
   input  logic                          firing_data,
   output logic [MEM_ADDRESS_LENGTH-1:0] row_select,
   output logic [MEM_ADDRESS_LENGTH-1:0] col_select,
   output logic                          row_col_select,
   output logic                          drive_enable,
   output logic                          drive_data,
   output logic                          busy,
   output logic                          frame_done
);

   localparam int unsigned MAL = MEM_ADDRESS_LENGTH;
   localparam int unsigned DW  = DWELL_WIDTH;
   localparam logic [MAL-1:0] LP_MAX_IDX = MAL'(MEM_LENGTH - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SETTLE  = 2'd1,
      S_FIRE    = 2'd2,
      S_ADVANCE = 2'd3
   } state_t;

   state_t         r_state,        w_state_nxt;
   logic [MAL-1:0] r_row,          w_row_nxt;
   logic [MAL-1:0] r_col,          w_col_nxt;
   logic [DW-1:0]  r_cnt,          w_cnt_nxt;
   logic [MAL-1:0] r_last_row,     w_last_row_nxt;
   logic [MAL-1:0] r_last_col,     w_last_col_nxt;
   logic [DW-1:0]  r_dwell,        w_dwell_nxt;
   logic           r_loop,         w_loop_nxt;
   logic           r_rcs,          w_rcs_nxt;
   logic           r_drive_data,   w_drive_data_nxt;
   logic           r_frame_done,   w_frame_done_nxt;
   logic           r_drive_enable;
   logic           r_busy;
   logic           w_last_dot;

   assign w_last_dot = (r_row == r_last_row) && (r_col == r_last_col);

   // Next-state, address walk and registered-output precomputation
   always_comb begin
      w_state_nxt      = r_state;
      w_row_nxt        = r_row;
      w_col_nxt        = r_col;
      w_cnt_nxt        = r_cnt;
      w_last_row_nxt   = r_last_row;
      w_last_col_nxt   = r_last_col;
      w_dwell_nxt      = r_dwell;
      w_loop_nxt       = r_loop;
      w_rcs_nxt        = r_rcs;
      w_drive_data_nxt = r_drive_data;
      w_frame_done_nxt = 1'b0;

      case (r_state)
         S_IDLE: begin
            if (start && !stop) begin
               w_last_row_nxt = (last_row > LP_MAX_IDX) ? LP_MAX_IDX : last_row;
               w_last_col_nxt = (last_col > LP_MAX_IDX) ? LP_MAX_IDX : last_col;
               w_dwell_nxt    = (dwell_cycles == '0) ? DW'(1) : dwell_cycles;
               w_loop_nxt     = loop_enable;
               w_rcs_nxt      = col_major_sel;
               w_row_nxt      = '0;
               w_col_nxt      = '0;
               w_state_nxt    = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (firing_bit) begin
               w_state_nxt      = S_FIRE;
               w_cnt_nxt        = r_dwell;
               w_drive_data_nxt = firing_data;
            end else begin
               w_state_nxt      = S_ADVANCE;
               w_frame_done_nxt = w_last_dot;
            end
         end
         S_FIRE: begin
            if (r_cnt == DW'(1)) begin
               w_state_nxt      = S_ADVANCE;
               w_frame_done_nxt = w_last_dot;
            end else begin
               w_cnt_nxt = r_cnt - DW'(1);
            end
         end
         S_ADVANCE: begin
            if (w_last_dot) begin
               w_row_nxt   = '0;
               w_col_nxt   = '0;
               w_state_nxt = r_loop ? S_SETTLE : S_IDLE;
            end else begin
               if (r_col == r_last_col) begin
                  w_col_nxt = '0;
                  w_row_nxt = r_row + MAL'(1);
               end else begin
                  w_col_nxt = r_col + MAL'(1);
               end
               w_state_nxt = S_SETTLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase

      // Abort wins over everything, including the pulse of a final dot
      if ((r_state != S_IDLE) && stop) begin
         w_state_nxt      = S_IDLE;
         w_row_nxt        = '0;
         w_col_nxt        = '0;
         w_frame_done_nxt = 1'b0;
      end

      if (w_state_nxt != S_FIRE) begin
         w_drive_data_nxt = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state        <= S_IDLE;
         r_row          <= '0;
         r_col          <= '0;
         r_cnt          <= '0;
         r_last_row     <= '0;
         r_last_col     <= '0;
         r_dwell        <= '0;
         r_loop         <= 1'b0;
         r_rcs          <= 1'b0;
         r_drive_data   <= 1'b0;
         r_frame_done   <= 1'b0;
         r_drive_enable <= 1'b0;
         r_busy         <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_row          <= w_row_nxt;
         r_col          <= w_col_nxt;
         r_cnt          <= w_cnt_nxt;
         r_last_row     <= w_last_row_nxt;
         r_last_col     <= w_last_col_nxt;
         r_dwell        <= w_dwell_nxt;
         r_loop         <= w_loop_nxt;
         r_rcs          <= w_rcs_nxt;
         r_drive_data   <= w_drive_data_nxt;
         r_frame_done   <= w_frame_done_nxt;
         r_drive_enable <= (w_state_nxt == S_FIRE);
         r_busy         <= (w_state_nxt != S_IDLE);
      end
   end

   assign row_select     = r_row;
   assign col_select     = r_col;
   assign row_col_select = r_rcs;
   assign drive_enable   = r_drive_enable;
   assign drive_data     = r_drive_data;
   assign busy           = r_busy;
   assign frame_done     = r_frame_done;

endmodule

// File: tb/tb_dot_scan_controller.sv
// Directed bench for dot_scan_controller: pattern-store model plus per-scenario cycle checks.
module tb_dot_scan_controller;

   logic        clock;
   logic        reset_n;
   logic        start;
   logic        stop;
   logic        loop_enable;
   logic        col_major_sel;
   logic [5:0]  last_row;
   logic [5:0]  last_col;
   logic [15:0] dwell_cycles;
   logic        firing_bit;
   logic        firing_data;
   logic [5:0]  row_select;
   logic [5:0]  col_select;
   logic        row_col_select;
   logic        drive_enable;
   logic        drive_data;
   logic        busy;
   logic        frame_done;

   int checks = 0;
   int errors = 0;

   logic mem_bit [0:63][0:63];
   logic mem_dat [0:63][0:63];

   assign firing_bit  = mem_bit[row_select][col_select];
   assign firing_data = mem_dat[row_select][col_select];

   dot_scan_controller #(
      .MEM_LENGTH(48), .MEM_ADDRESS_LENGTH(6), .DWELL_WIDTH(16)
   ) dut (
      .clock(clock), .reset_n(reset_n), .start(start), .stop(stop),
      .loop_enable(loop_enable), .col_major_sel(col_major_sel),
      .last_row(last_row), .last_col(last_col), .dwell_cycles(dwell_cycles),
      .firing_bit(firing_bit), .firing_data(firing_data),
      .row_select(row_select), .col_select(col_select),
      .row_col_select(row_col_select), .drive_enable(drive_enable),
      .drive_data(drive_data), .busy(busy), .frame_done(frame_done)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_mem();
      for (int r = 0; r < 64; r++)
         for (int c = 0; c < 64; c++) begin
            mem_bit[r][c] = 1'b0;
            mem_dat[r][c] = 1'b0;
         end
   endtask

   // Pulse start for one cycle; returns positioned in the first scan cycle (c=1)
   task automatic begin_scan();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({busy, drive_enable, drive_data, frame_done, row_col_select, row_select, col_select} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outputs: got busy=%b de=%b dd=%b fd=%b rcs=%b row=%0d col=%0d, want all 0",
                  busy, drive_enable, drive_data, frame_done, row_col_select, row_select, col_select);
      end
      #6 reset_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%b want 0", busy);
      end
   endtask

   task automatic test_stop_priority();
      start = 1'b1;
      stop  = 1'b1;
      tick();
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_over_start: busy=%b want 0", busy);
      end
      start = 1'b0;
      stop  = 1'b0;
      tick();
   endtask

   // 2x2 window, every dot set, dwell 3: four 5-cycle dots
   task automatic test_full_window();
      logic exp_busy, exp_de, exp_fd, exp_dd;
      logic [5:0] exp_row, exp_col;
      int idx, ph;
      clear_mem();
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++) begin
            mem_bit[r][c] = 1'b1;
            mem_dat[r][c] = 1'((r + c) % 2);
         end
      last_row = 6'd1; last_col = 6'd1; dwell_cycles = 16'd3;
      loop_enable = 1'b0; col_major_sel = 1'b1;
      begin_scan();
      col_major_sel = 1'b0;
      for (int c = 1; c <= 22; c++) begin
         idx = (c - 1) / 5;
         ph  = (c - 1) % 5;
         exp_busy = (c <= 20);
         exp_de   = (c <= 20) && (ph >= 1) && (ph <= 3);
         exp_fd   = (c == 20);
         exp_row  = (c <= 20) ? 6'(idx / 2) : 6'd0;
         exp_col  = (c <= 20) ? 6'(idx % 2) : 6'd0;
         exp_dd   = 1'(((idx / 2) + (idx % 2)) % 2);
         checks++;
         if ({busy, drive_enable, frame_done} !== {exp_busy, exp_de, exp_fd}) begin
            errors++;
            $display("FAIL full_ctrl c=%0d: busy/de/fd=%b%b%b want %b%b%b",
                     c, busy, drive_enable, frame_done, exp_busy, exp_de, exp_fd);
         end
         checks++;
         if ({row_select, col_select} !== {exp_row, exp_col}) begin
            errors++;
            $display("FAIL full_addr c=%0d: row=%0d col=%0d want row=%0d col=%0d",
                     c, row_select, col_select, exp_row, exp_col);
         end
         if (exp_de) begin
            checks++;
            if (drive_data !== exp_dd) begin
               errors++;
               $display("FAIL full_data c=%0d: drive_data=%b want %b", c, drive_data, exp_dd);
            end
         end
         if (c <= 20) begin
            checks++;
            if (row_col_select !== 1'b1) begin
               errors++;
               $display("FAIL full_rcs c=%0d: row_col_select=%b want 1", c, row_col_select);
            end
         end
         tick();
      end
   endtask

   // Only dot (1,0) set: clear dots take 2 cycles, set dot 5; start re-pulse while busy is ignored
   task automatic test_single_dot();
      logic exp_de, exp_fd, exp_busy;
      clear_mem();
      mem_bit[1][0] = 1'b1;
      mem_dat[1][0] = 1'b1;
      last_row = 6'd1; last_col = 6'd1; dwell_cycles = 16'd3;
      begin_scan();
      for (int c = 1; c <= 14; c++) begin
         start    = (c == 3);
         exp_de   = (c >= 6) && (c <= 8);
         exp_fd   = (c == 11);
         exp_busy = (c <= 11);
         checks++;
         if ({busy, drive_enable, frame_done} !== {exp_busy, exp_de, exp_fd}) begin
            errors++;
            $display("FAIL single_ctrl c=%0d: busy/de/fd=%b%b%b want %b%b%b",
                     c, busy, drive_enable, frame_done, exp_busy, exp_de, exp_fd);
         end
         if (exp_de) begin
            checks++;
            if (drive_data !== 1'b1) begin
               errors++;
               $display("FAIL single_data c=%0d: drive_data=%b want 1", c, drive_data);
            end
         end
         tick();
      end
      start = 1'b0;
   endtask

   // dwell 0 behaves as 1 on a 1x1 window
   task automatic test_dwell_zero();
      clear_mem();
      mem_bit[0][0] = 1'b1;
      last_row = 6'd0; last_col = 6'd0; dwell_cycles = 16'd0;
      begin_scan();
      for (int c = 1; c <= 5; c++) begin
         checks++;
         if ({busy, drive_enable, frame_done} !== {1'(c <= 3), 1'(c == 2), 1'(c == 3)}) begin
            errors++;
            $display("FAIL dwell0 c=%0d: busy/de/fd=%b%b%b want %b%b%b", c, busy, drive_enable,
                     frame_done, 1'(c <= 3), 1'(c == 2), 1'(c == 3));
         end
         tick();
      end
   endtask

   task automatic test_loop();
      logic [5:0] exp_col;
      clear_mem();
      last_row = 6'd0; last_col = 6'd1; dwell_cycles = 16'd2; loop_enable = 1'b1;
      begin_scan();
      loop_enable = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         exp_col = 6'(((c - 1) / 2) % 2);
         checks++;
         if ({busy, frame_done, row_select, col_select} !== {1'b1, 1'(c % 4 == 0), 6'd0, exp_col}) begin
            errors++;
            $display("FAIL loop c=%0d: busy=%b fd=%b row=%0d col=%0d want busy=1 fd=%b row=0 col=%0d",
                     c, busy, frame_done, row_select, col_select, 1'(c % 4 == 0), exp_col);
         end
         tick();
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({busy, row_select, col_select} !== 13'd0) begin
         errors++;
         $display("FAIL loop_stop: busy=%b row=%0d col=%0d want 0/0/0", busy, row_select, col_select);
      end
   endtask

   // Stop during FIRE of (2,5) in a 4x8 window, then a clean rerun
   task automatic test_stop_mid_fire();
      int c, first_de, de_cnt, fd_cnt, fd_at;
      clear_mem();
      mem_bit[2][5] = 1'b1;
      last_row = 6'd3; last_col = 6'd7; dwell_cycles = 16'd4;
      begin_scan();
      c = 1;
      while (drive_enable !== 1'b1 && c < 100) begin
         tick();
         c++;
      end
      checks++;
      if (c != 44 || row_select !== 6'd2 || col_select !== 6'd5) begin
         errors++;
         $display("FAIL stop_reach: fire at c=%0d row=%0d col=%0d want c=44 row=2 col=5",
                  c, row_select, col_select);
      end
      tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      checks++;
      if ({busy, drive_enable, frame_done, row_select, col_select} !== 15'd0) begin
         errors++;
         $display("FAIL stop_abort: busy=%b de=%b fd=%b row=%0d col=%0d want all 0",
                  busy, drive_enable, frame_done, row_select, col_select);
      end
      fd_cnt = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (frame_done === 1'b1) fd_cnt++;
      end
      checks++;
      if (fd_cnt != 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_quiet: frame_done pulses=%0d busy=%b want 0/0", fd_cnt, busy);
      end
      begin_scan();
      first_de = 0; de_cnt = 0; fd_cnt = 0; fd_at = 0;
      for (int k = 1; k <= 72; k++) begin
         if (drive_enable === 1'b1) begin
            de_cnt++;
            if (first_de == 0) first_de = k;
         end
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_at = k;
         end
         tick();
      end
      checks++;
      if (first_de != 44 || de_cnt != 4 || fd_cnt != 1 || fd_at != 68) begin
         errors++;
         $display("FAIL stop_rerun: first_de=%0d de_cycles=%0d fd=%0d at %0d want 44/4/1/68",
                  first_de, de_cnt, fd_cnt, fd_at);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL stop_rerun_idle: busy=%b want 0", busy);
      end
   endtask

   // last_col=63 clamps to 47; config changes mid-scan are ignored
   task automatic test_clamp_and_config_hold();
      int max_col, de_cnt, fd_at, fd_cnt;
      clear_mem();
      mem_bit[0][10] = 1'b1;
      last_row = 6'd0; last_col = 6'd63; dwell_cycles = 16'd2; loop_enable = 1'b0;
      begin_scan();
      max_col = 0; de_cnt = 0; fd_at = 0; fd_cnt = 0;
      for (int k = 1; k <= 102; k++) begin
         if (k == 5) begin
            dwell_cycles = 16'd9;
            last_col     = 6'd3;
            loop_enable  = 1'b1;
         end
         if (int'(col_select) > max_col) max_col = int'(col_select);
         if (drive_enable === 1'b1) de_cnt++;
         if (frame_done === 1'b1) begin
            fd_cnt++;
            fd_at = k;
         end
         tick();
      end
      checks++;
      if (max_col != 47) begin
         errors++;
         $display("FAIL clamp_col: max col_select=%0d want 47", max_col);
      end
      checks++;
      if (de_cnt != 2) begin
         errors++;
         $display("FAIL cfg_hold_dwell: drive cycles=%0d want 2", de_cnt);
      end
      checks++;
      if (fd_cnt != 1 || fd_at != 98 || busy !== 1'b0) begin
         errors++;
         $display("FAIL clamp_frame: fd=%0d at %0d busy=%b want 1 at 98 busy=0", fd_cnt, fd_at, busy);
      end
      loop_enable = 1'b0;
   endtask

   task automatic test_async_reset();
      int c;
      clear_mem();
      mem_bit[0][1] = 1'b1;
      mem_dat[0][1] = 1'b1;
      last_row = 6'd1; last_col = 6'd1; dwell_cycles = 16'd5; col_major_sel = 1'b1;
      begin_scan();
      c = 0;
      while (drive_enable !== 1'b1 && c < 20) begin
         tick();
         c++;
      end
      checks++;
      if (drive_enable !== 1'b1 || drive_data !== 1'b1 || row_col_select !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: de=%b dd=%b rcs=%b want 1/1/1", drive_enable, drive_data, row_col_select);
      end
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({busy, drive_enable, drive_data, frame_done, row_col_select, row_select, col_select} !== 17'd0) begin
         errors++;
         $display("FAIL areset_now: busy=%b de=%b dd=%b fd=%b rcs=%b row=%0d col=%0d want all 0",
                  busy, drive_enable, drive_data, frame_done, row_col_select, row_select, col_select);
      end
      tick();
      tick();
      checks++;
      if ({busy, drive_enable, frame_done} !== 3'd0) begin
         errors++;
         $display("FAIL areset_hold: busy=%b de=%b fd=%b want 0", busy, drive_enable, frame_done);
      end
      #3 reset_n = 1'b1;
      tick();
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_enable = 1'b0; col_major_sel = 1'b0;
      last_row = '0; last_col = '0; dwell_cycles = '0;
      clear_mem();
      test_reset();
      test_stop_priority();
      test_full_window();
      test_single_dot();
      test_dwell_zero();
      test_loop();
      test_stop_mid_fire();
      test_clamp_and_config_hold();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
